// File: rtl/fp_acc.sv
// Binary32 running-sum accumulator fed by fp_mul: z <= z + a over a fixed
// seven-state pipeline-in-time (six clocks from accept to result).
module fp_acc #(
   parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clr,
   input  logic [31:0] a,
   output logic        busy,
   output logic        done,
   output logic [31:0] z
);

   localparam int unsigned EW = 10;   // signed working exponent width
   localparam int unsigned MW = 27;   // hidden + 23 fraction + guard/round/sticky

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
   } state_t;

   state_t state, state_nx;

   logic [31:0]          op_a, op_b;
   logic                 ua_s, ub_s;
   logic [7:0]           ua_e, ub_e;
   logic [23:0]          ua_m, ub_m;
   logic                 spec;
   logic [31:0]          spec_z;
   logic                 al_s, sm_s;
   logic [7:0]           al_e;
   logic [MW-1:0]        al_m, sm_m;
   logic                 ad_s;
   logic [7:0]           ad_e;
   logic [MW:0]          ad_sum;
   logic                 nm_s, nm_zero;
   logic signed [EW-1:0] nm_e;
   logic [MW-1:0]        nm_m;
   logic                 rd_s, rd_zero;
   logic signed [EW-1:0] rd_e;
   logic [22:0]          rd_f;

   // Priority encoder: leading-zero count of a nonzero 27-bit magnitude
   function automatic logic [4:0] lzc27(input logic [MW-1:0] v);
      lzc27 = 5'd0;
      for (int i = 0; i < int'(MW); i++)
         if (v[i]) lzc27 = 5'(int'(MW) - 1 - i);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (rdy) state_nx = S_UNPACK;
         S_UNPACK: state_nx = S_ALIGN;
         S_ALIGN:  state_nx = S_ADD;
         S_ADD:    state_nx = S_NORM;
         S_NORM:   state_nx = S_ROUND;
         S_ROUND:  state_nx = S_PACK;
         S_PACK:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic        u_spec;
   logic [31:0] u_spec_z;
   logic        a_big, l_s, s_s;
   logic [7:0]  l_e, s_e, diff;
   logic [23:0] l_m, s_m;
   logic [53:0] wide;
   logic [MW-1:0] s_al;
   logic [MW:0] sum_c;
   logic [4:0]  lz;
   logic [MW-1:0] n_m;
   logic signed [EW-1:0] n_e;
   logic        rup;
   logic [24:0] r_m;
   logic [22:0] r_f;
   logic signed [EW-1:0] r_e;
   logic [31:0] z_nx;

   always_comb begin
      // UNPACK: special-value resolution
      a_nan    = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
      b_nan    = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
      a_inf    = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
      b_inf    = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
      a_zero   = (op_a[30:23] == 8'h00);
      b_zero   = (op_b[30:23] == 8'h00);
      u_spec   = 1'b1;
      u_spec_z = 32'h7FC0_0000;
      if (a_nan || b_nan || (a_inf && b_inf && (op_a[31] != op_b[31]))) u_spec_z = 32'h7FC0_0000;
      else if (a_inf)                u_spec_z = op_a;
      else if (b_inf)                u_spec_z = op_b;
      else if (a_zero && b_zero)     u_spec_z = {op_a[31] & op_b[31], 31'd0};
      else                           u_spec   = 1'b0;

      // ALIGN: larger magnitude first, smaller shifted with sticky collection
      a_big = {ua_e, ua_m} >= {ub_e, ub_m};
      l_s   = a_big ? ua_s : ub_s;
      s_s   = a_big ? ub_s : ua_s;
      l_e   = a_big ? ua_e : ub_e;
      s_e   = a_big ? ub_e : ua_e;
      l_m   = a_big ? ua_m : ub_m;
      s_m   = a_big ? ub_m : ua_m;
      diff  = l_e - s_e;
      wide  = {s_m, 30'd0} >> diff;
      if (diff >= 8'd26) s_al = {26'd0, |s_m};
      else               s_al = {wide[53:28], wide[27] | (|wide[26:0])};

      // ADD: magnitudes, result sign is that of the larger operand
      if (al_s == sm_s) sum_c = {1'b0, al_m} + {1'b0, sm_m};
      else              sum_c = {1'b0, al_m} - {1'b0, sm_m};

      // NORM
      lz = lzc27(ad_sum[MW-1:0]);
      if (ad_sum[MW]) begin
         n_m = {ad_sum[MW:2], ad_sum[1] | ad_sum[0]};
         n_e = $signed({2'b00, ad_e}) + 10'sd1;
      end else begin
         n_m = ad_sum[MW-1:0] << lz;
         n_e = $signed({2'b00, ad_e}) - $signed({5'd0, lz});
      end

      // ROUND: nearest, ties to even
      rup = nm_m[2] & (nm_m[1] | nm_m[0] | nm_m[3]);
      r_m = {1'b0, nm_m[MW-1:3]} + 25'(rup);
      if (r_m[24]) begin
         r_f = r_m[23:1];
         r_e = nm_e + 10'sd1;
      end else begin
         r_f = r_m[22:0];
         r_e = nm_e;
      end

      // PACK
      if (spec)                  z_nx = spec_z;
      else if (rd_zero)          z_nx = 32'h0000_0000;
      else if (rd_e >= 10'sd255) z_nx = {rd_s, 8'hFF, 23'd0};
      else if (rd_e <= 10'sd0)   z_nx = {rd_s, 31'd0};
      else                       z_nx = {rd_s, rd_e[7:0], rd_f};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nx != S_IDLE);
         done <= (state == S_PACK);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z <= ACC_INIT;
         op_a <= '0;  op_b <= '0;
         ua_s <= 1'b0; ub_s <= 1'b0; ua_e <= '0; ub_e <= '0; ua_m <= '0; ub_m <= '0;
         spec <= 1'b0; spec_z <= '0;
         al_s <= 1'b0; sm_s <= 1'b0; al_e <= '0; al_m <= '0; sm_m <= '0;
         ad_s <= 1'b0; ad_e <= '0; ad_sum <= '0;
         nm_s <= 1'b0; nm_zero <= 1'b0; nm_e <= '0; nm_m <= '0;
         rd_s <= 1'b0; rd_zero <= 1'b0; rd_e <= '0; rd_f <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rdy) begin
                  op_a <= a;
                  op_b <= clr ? ACC_INIT : z;
               end else if (clr) begin
                  z <= ACC_INIT;
               end
            end
            S_UNPACK: begin
               ua_s   <= op_a[31];
               ub_s   <= op_b[31];
               ua_e   <= op_a[30:23];
               ub_e   <= op_b[30:23];
               ua_m   <= a_zero ? 24'd0 : {1'b1, op_a[22:0]};
               ub_m   <= b_zero ? 24'd0 : {1'b1, op_b[22:0]};
               spec   <= u_spec;
               spec_z <= u_spec_z;
            end
            S_ALIGN: begin
               al_s <= l_s;
               sm_s <= s_s;
               al_e <= l_e;
               al_m <= {l_m, 3'd0};
               sm_m <= s_al;
            end
            S_ADD: begin
               ad_s   <= al_s;
               ad_e   <= al_e;
               ad_sum <= sum_c;
            end
            S_NORM: begin
               nm_s    <= ad_s;
               nm_zero <= (ad_sum == '0);
               nm_e    <= n_e;
               nm_m    <= n_m;
            end
            S_ROUND: begin
               rd_s    <= nm_s;
               rd_zero <= nm_zero;
               rd_e    <= r_e;
               rd_f    <= r_f;
            end
            S_PACK: z <= z_nx;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fp_acc.md
Name: fp_acc

Overview:
- Single-precision (IEEE-754 binary32) accumulator that sits directly downstream of the fp_mul stage.
- Each accepted product is added into an internal running sum: acc <= acc + a.
- Together with fp_mul it forms a multi-cycle MAC path for dot products.
- Uses the same rdy-pulse operand handshake as the multiplier and reports completion with a one-cycle done pulse.

Parameters:
- ACC_INIT, 32'h00000000, accumulator value loaded on reset and on clr (binary32 pattern).

Ports:
- clk    input   1   rising-edge clock.
- rst    input   1   asynchronous, active-low reset (0 = reset asserted).
- rdy    input   1   one-cycle pulse: a is valid; sampled only in IDLE.
- clr    input   1   synchronous clear of the accumulator to ACC_INIT; sampled only in IDLE.
- a      input   32  binary32 addend (the fp_mul z output).
- busy   output  1   high while an addition is in flight (any state other than IDLE).
- done   output  1   one-cycle pulse; z holds the new sum in that cycle.
- z      output  32  current accumulator value (binary32).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, z=ACC_INIT, busy=0, done=0, all internal registers cleared.
  - Takes effect immediately, including mid-operation; the in-flight addition is discarded.
- FSM states: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> PACK -> IDLE. One clock per state, no stalls.
- IDLE, rdy=1 at edge E0: capture a and z; go to UNPACK.
  - busy=1 from E0 through E6.
  - At edge E6, z is updated and done=1 for exactly one cycle; state returns to IDLE.
  - Fixed latency: 6 clocks from the accepting edge to the z update.
- rdy or clr asserted while busy=1: ignored, not queued. Upstream must wait until busy=0.
- IDLE, clr=1, rdy=0: z <= ACC_INIT at the next edge; done stays 0.
- IDLE, clr=1 and rdy=1 in the same cycle: the sum is computed as ACC_INIT + a, so the result is a itself when ACC_INIT is +0.
- UNPACK:
  - Split both operands into sign, 8-bit exponent and 24-bit significand with the hidden bit.
  - Denormal inputs (exp=0) are flushed to signed zero.
- ALIGN:
  - Swap operands so the larger magnitude is the first operand.
  - Right-shift the smaller significand by the exponent difference into a 27-bit field (guard, round, sticky).
  - A difference of 26 or more leaves only the sticky bit.
- ADD:
  - Same signs: add magnitudes (28-bit result).
  - Different signs: subtract smaller magnitude from larger; the result takes the sign of the larger.
- NORM:
  - Carry out: shift right by 1, exponent +1, sticky ORs in the shifted-out bit.
  - Otherwise: left-shift by the leading-zero count, using a single-cycle priority encoder.
  - A zero magnitude goes to the zero result.
- ROUND: round to nearest, ties to even. A rounding carry renormalises the result (exponent +1).
- PACK:
  - Exponent >= 255: +/-infinity.
  - Exponent <= 0 after normalisation: signed zero (flush-to-zero, no denormal outputs).
  - Exact cancellation gives +0.
- Special values, resolved in UNPACK with the arithmetic path bypassed (latency is still 6):
  - Any NaN operand, or +inf added to -inf: z=32'h7FC00000.
  - One infinity: result is that infinity.
  - +0 + -0 = +0; -0 + -0 = -0.
- z is stable at all times except at the PACK edge and the clr edge.

Test Plan:
- Reset with rst=0 mid-run (during the ALIGN state), then release -> z=32'h00000000, busy=0, no done pulse.
- a=32'h40C00000 (6.0) then a=32'h41100000 (9.0) -> z=32'h40C00000, then z=32'h41700000 (15.0). Each done exactly 6 clocks after its rdy; busy high for 6 cycles each.
- From 15.0, a=32'hC1700000 (-15.0) -> z=32'h00000000. Then a=32'h00000000 -> z stays 32'h00000000.
- clr with rdy=0 -> z=32'h00000000 next cycle, no done pulse. Then clr+rdy together with a=32'h3F800000 -> z=32'h3F800000.
- With z=32'h4B800000 (2^24), a=32'h3F800000 (1.0) -> z unchanged (tie, rounds to even). Then a=32'h40000000 (2.0) -> z=32'h4B800001.
- a=32'h7F800000 (+inf) then a=32'hFF800000 (-inf) -> z=32'h7F800000, then 32'h7FC00000. A rdy pulse sent while busy=1 produces no extra done pulse.
